// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the valid/ready pipeline blocks.
//   pipe_state_e : occupancy-encoded stage state (EMPTY=0, ONE=1, TWO=2), so a
//                  stage can drive its occupancy output straight from the state.
//   hs_fire      : handshake-fire helper, a transfer happens when valid & ready.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // The state encoding doubles as the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // A beat moves across a valid/ready boundary only when both sides agree.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// -----------------------------------------------------------------------------
// pipe_data_reg
// Parametrised data register with synchronous reset and load-enable.
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset, loads RESET_VAL
//   load  : capture d on the next edge when high, otherwise hold
//   d     : WIDTH-bit input data
//   q     : WIDTH-bit registered output
// -----------------------------------------------------------------------------
module pipe_data_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next value: new data when loading, otherwise keep what we hold.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  // Storage flop; reset wins over any load in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer. Sustains one transfer per cycle while in_ready is a registered
// function of state only, so there is no combinational out_ready->in_ready
// path and no in_valid->out_valid path.
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-high reset, empties stage, data <= RESET_VAL
//   flush     : empty the stage this cycle; an accepted input is discarded,
//               a delivered output still counts, data registers keep contents
//   in_valid  : upstream presents in_data
//   in_ready  : stage can accept (registered)
//   in_data   : upstream payload
//   out_valid : out_data holds a valid entry (registered)
//   out_ready : downstream accepts
//   out_data  : payload, driven directly from the main register
//   occupancy : number of held entries (0, 1 or 2)
// -----------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_d, state_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             in_fire, out_fire;
  logic             main_load, skid_load, main_from_skid;
  logic [WIDTH-1:0] main_in, main_data, skid_data;

  assign in_fire  = hs_fire(in_valid, in_ready_q);
  assign out_fire = hs_fire(out_valid_q, out_ready);

  // Next-state and load-enable decode. The main register normally takes
  // in_data; only the TWO->ONE drain refills it from the skid register.
  // Flush forces EMPTY and suppresses every load, which discards any input
  // accepted this cycle while leaving the stored data untouched.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  assign main_in = main_from_skid ? skid_data : in_data;

  // State and handshake outputs are registered together so in_ready and
  // out_valid depend only on the stored state. Reset overrides flush and
  // any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .load(main_load),
    .d   (main_in),
    .q   (main_data)
  );

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .load(skid_load),
    .d   (in_data),
    .q   (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench for pipe_skid_reg. An 8-bit instance with RESET_VAL
// 8'hA5 is driven from a table of directed vectors plus a streaming sequence;
// 1-bit and 64-bit instances are then exercised with random valid/ready/flush
// against a queue model.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush8, iv8, ordy8;
  logic [7:0]  din8;
  logic        ir8, ov8;
  logic [7:0]  dout8;
  logic [1:0]  occ8;

  logic        flush_r, iv1, ordy1, iv64, ordy64;
  logic [0:0]  din1, dout1;
  logic [63:0] din64, dout64;
  logic        ir1, ov1, ir64, ov64;
  logic [1:0]  occ1, occ64;

  int passed = 0;
  int total  = 0;

  pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .flush(flush8),
    .in_valid(iv8), .in_ready(ir8), .in_data(din8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(dout8),
    .occupancy(occ8)
  );

  pipe_skid_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush_r),
    .in_valid(iv1), .in_ready(ir1), .in_data(din1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(dout1),
    .occupancy(occ1)
  );

  pipe_skid_reg #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush_r),
    .in_valid(iv64), .in_ready(ir64), .in_data(din64),
    .out_valid(ov64), .out_ready(ordy64), .out_data(dout64),
    .occupancy(occ64)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_data;
    logic [1:0] e_occ;
  } vec_t;

  vec_t vecs[22];

  // One comparison: bumps the counters and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the 8-bit instance, then step past the edge.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [7:0] d, input logic o);
    rst    = r;
    flush8 = f;
    iv8    = v;
    din8   = d;
    ordy8  = o;
    @(posedge clk);
    #1;
  endtask

  logic [0:0]  q1[$];
  logic [63:0] q64[$];
  logic        stall1, stall64;
  logic [0:0]  held1;
  logic [63:0] held64;
  logic        f1, f64;

  initial begin
    rst = 1'b0; flush8 = 1'b0; iv8 = 1'b0; din8 = '0; ordy8 = 1'b0;
    flush_r = 1'b0; iv1 = 1'b0; din1 = '0; ordy1 = 1'b0;
    iv64 = 1'b0; din64 = '0; ordy64 = 1'b0;

    //            rst flush iv din    ordy  ir ov data   occ
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 2'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'h02, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 2'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h03, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0B, 2'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h0B, 2'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 8'h0C, 2'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 8'h0C, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h0E, 1'b0, 1'b1, 1'b0, 8'h0C, 2'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h0C, 2'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h11, 2'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 2'd1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h33, 2'd2};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66, 2'd1};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h66, 2'd1};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h66, 2'd1};

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      checkOutput($sformatf("vec%0d in_ready", i),  64'(ir8),   64'(vecs[i].e_ir));
      checkOutput($sformatf("vec%0d out_valid", i), 64'(ov8),   64'(vecs[i].e_ov));
      checkOutput($sformatf("vec%0d out_data", i),  64'(dout8), 64'(vecs[i].e_data));
      checkOutput($sformatf("vec%0d occupancy", i), 64'(occ8),  64'(vecs[i].e_occ));
    end

    // Back-to-back stream with out_ready held: each beat appears one cycle
    // after it is offered and the stage never fills up.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h70 + 8'(k), 1'b1);
      checkOutput($sformatf("stream%0d out_data", k),  64'(dout8), 64'(8'h70 + 8'(k)));
      checkOutput($sformatf("stream%0d in_ready", k),  64'(ir8),   64'd1);
      checkOutput($sformatf("stream%0d occupancy", k), 64'(occ8),  64'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("stream drain out_valid", 64'(ov8), 64'd0);

    // Random phase on the 1-bit and 64-bit instances against queue models.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q64.delete();
    stall1 = 1'b0;
    stall64 = 1'b0;
    held1 = '0;
    held64 = '0;
    for (int c = 0; c < 10000; c++) begin
      checkOutput("rand w1 occupancy",  64'(occ1),  64'(q1.size()));
      checkOutput("rand w64 occupancy", 64'(occ64), 64'(q64.size()));
      checkOutput("rand w1 out_valid",  64'(ov1),   64'(q1.size() != 0));
      checkOutput("rand w64 out_valid", 64'(ov64),  64'(q64.size() != 0));
      if (stall1) checkOutput("rand w1 stall hold", 64'(dout1), 64'(held1));
      if (stall64) checkOutput("rand w64 stall hold", dout64, held64);

      flush_r = ($urandom_range(63) == 0);
      iv1     = 1'($urandom_range(1));
      ordy1   = 1'($urandom_range(1));
      din1    = 1'($urandom_range(1));
      iv64    = 1'($urandom_range(1));
      ordy64  = 1'($urandom_range(1));
      din64   = {$urandom, $urandom};

      f1 = ov1 & ordy1;
      if (f1) begin
        if (q1.size() != 0) checkOutput("rand w1 order", 64'(dout1), 64'(q1[0]));
        if (q1.size() != 0) void'(q1.pop_front());
      end
      if (flush_r) q1.delete();
      else if (iv1 & ir1) q1.push_back(din1);
      stall1 = ov1 & ~ordy1 & ~flush_r;
      held1  = dout1;

      f64 = ov64 & ordy64;
      if (f64) begin
        if (q64.size() != 0) checkOutput("rand w64 order", dout64, q64[0]);
        if (q64.size() != 0) void'(q64.pop_front());
      end
      if (flush_r) q64.delete();
      else if (iv64 & ir64) q64.push_back(din64);
      stall64 = ov64 & ~ordy64 & ~flush_r;
      held64  = dout64;

      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
